// File: rtl/gun_pkg.sv
//==============================================================================
// Module      : gun_pkg
// Description : Shared definitions for the light-gun aim controller.
//               Holds the per-axis state type, the position width and range,
//               and the 0..63 saturation helper.
// Ports       : none (package)
// Config      : GUN_MOUSE_EN is not referenced here.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gun_pkg;

    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_SLOW = 2'd1,
        AX_FAST = 2'd2
    } gun_axis_st_t;

    localparam int GUN_W   = 6;
    localparam int GUN_MAX = 63;

    // Clamp a signed 8-bit candidate position into 0..GUN_MAX.
    function automatic logic [GUN_W-1:0] sat6(input logic signed [7:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > GUN_MAX) begin
            return GUN_W'(GUN_MAX);
        end else begin
            return v[GUN_W-1:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/gun_axis_ctrl.sv
//==============================================================================
// Module      : gun_axis_ctrl
// Description : One crosshair axis. Joystick FSM (IDLE/SLOW/FAST) with hold
//               and divider counters, optional mouse accumulator, and the
//               combined signed step plus a flag telling whether pos+step
//               leaves 0..63.
// Ports       : clk_12, reset      clock / async active-high reset
//               i_tick_p           one-cycle tick pulse
//               i_recentre         forces IDLE and clears the mouse fraction
//               i_dir_neg/pos      direction inputs (both or neither = released)
//               i_mouse_stb        mouse delta valid
//               i_mouse_d          signed delta, already in axis orientation
//               i_pos              current axis position
//               o_step             joystick + mouse step, signed
//               o_sat              pos + o_step falls outside 0..63
//               o_joy_moved        joystick produced a step this cycle
//               o_mouse_moved      mouse produced a step this cycle
// Config      : GUN_MOUSE_EN enables the mouse accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gun_axis_ctrl
    import gun_pkg::*;
#(
    parameter int SLOW_DIV    = 3,
    parameter int ACCEL_TICKS = 16,
    parameter int MOUSE_SHIFT = 2
) (
    input  logic              clk_12,
    input  logic              reset,
    input  logic              i_tick_p,
    input  logic              i_recentre,
    input  logic              i_dir_neg,
    input  logic              i_dir_pos,
    input  logic              i_mouse_stb,
    input  logic signed [9:0] i_mouse_d,
    input  logic [GUN_W-1:0]  i_pos,
    output logic signed [7:0] o_step,
    output logic              o_sat,
    output logic              o_joy_moved,
    output logic              o_mouse_moved
);

    localparam int c_HOLD_W = $clog2(ACCEL_TICKS + 1);
    localparam int c_DIV_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [c_HOLD_W:0]   c_ACCEL    = (c_HOLD_W + 1)'(ACCEL_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [c_HOLD_W:0]   c_INC_ONE  = (c_HOLD_W + 1)'(1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SLOW_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_ONE  = c_DIV_W'(1);
    localparam logic signed [7:0]   c_STEP_P   = 8'sd1;
    localparam logic signed [7:0]   c_STEP_N   = -8'sd1;

    gun_axis_st_t          r_state, w_state_nxt;
    logic [c_HOLD_W-1:0]   r_hold, w_hold_nxt;
    logic [c_HOLD_W:0]     w_hold_inc;
    logic [c_DIV_W-1:0]    r_div, w_div_nxt;
    logic                  r_dir, w_dir_nxt;     // 1 = positive direction
    logic                  w_pressed;
    logic                  w_dir_in;
    logic                  w_new_press;
    logic signed [7:0]     w_joy_step;
    logic signed [7:0]     w_mouse_step;
    logic signed [8:0]     w_sum9;
    logic signed [7:0]     w_sum8;
    logic [GUN_W-1:0]      w_rail;

    assign w_pressed   = i_dir_neg ^ i_dir_pos;
    assign w_dir_in    = i_dir_pos;
    // A press from IDLE and a reversal both restart the slow profile.
    assign w_new_press = (r_state == AX_IDLE) || (w_dir_in != r_dir);
    assign w_hold_inc  = {1'b0, r_hold} + c_INC_ONE;

    // State register
    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            r_state <= AX_IDLE;
            r_hold  <= '0;
            r_div   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_div   <= w_div_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Next-state logic; directions are only looked at on a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_div_nxt   = r_div;
        w_dir_nxt   = r_dir;
        if (i_recentre) begin
            w_state_nxt = AX_IDLE;
            w_hold_nxt  = '0;
            w_div_nxt   = '0;
        end else if (i_tick_p) begin
            if (!w_pressed) begin
                w_state_nxt = AX_IDLE;
                w_hold_nxt  = '0;
                w_div_nxt   = '0;
            end else if (w_new_press) begin
                w_state_nxt = AX_SLOW;
                w_hold_nxt  = c_HOLD_ONE;
                w_div_nxt   = '0;
                w_dir_nxt   = w_dir_in;
            end else if (r_state == AX_SLOW) begin
                // hold never exceeds ACCEL_TICKS: FAST stops counting.
                w_hold_nxt = w_hold_inc[c_HOLD_W-1:0];
                w_div_nxt  = (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
                if (w_hold_inc >= c_ACCEL) begin
                    w_state_nxt = AX_FAST;
                end
            end
        end
    end

    // Output logic: joystick step decided from the current state and tick.
    always_comb begin
        w_joy_step = '0;
        if (i_tick_p && w_pressed && !i_recentre) begin
            if (w_new_press || (r_state == AX_FAST) || (r_div == c_DIV_LAST)) begin
                w_joy_step = w_dir_in ? c_STEP_P : c_STEP_N;
            end
        end
    end

`ifdef GUN_MOUSE_EN
    localparam int c_ACC_W = 9 + MOUSE_SHIFT;

    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [c_ACC_W-1:0] w_acc_sum;
    logic signed [c_ACC_W-1:0] w_acc_q;
    logic signed [c_ACC_W-1:0] w_acc_rem;

    assign w_acc_sum = r_acc + c_ACC_W'(i_mouse_d);
    // Arithmetic shift floors toward -inf, so the kept remainder is >= 0.
    assign w_acc_q   = w_acc_sum >>> MOUSE_SHIFT;
    assign w_acc_rem = w_acc_sum - (w_acc_q <<< MOUSE_SHIFT);

    assign w_mouse_step = (i_mouse_stb && !i_recentre) ? 8'(w_acc_q) : '0;

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_recentre || o_sat) begin
            // Leftover fraction is meaningless once pinned to an edge.
            r_acc <= '0;
        end else if (i_mouse_stb) begin
            r_acc <= w_acc_rem;
        end
    end
`else
    logic w_mouse_unused;

    assign w_mouse_unused = ^{i_mouse_stb, i_mouse_d};
    assign w_mouse_step   = '0;
`endif

    assign o_step        = w_joy_step + w_mouse_step;
    assign o_joy_moved   = (w_joy_step != 8'sd0);
    assign o_mouse_moved = (w_mouse_step != 8'sd0);

    // Sum in 9 bits so 63 + 65 cannot wrap before the range test.
    assign w_sum9 = $signed({3'b000, i_pos}) + $signed({o_step[7], o_step});
    assign w_sum8 = (w_sum9 > 9'sd127) ? 8'sd127 : w_sum9[7:0];
    assign w_rail = sat6(w_sum8);
    assign o_sat  = (w_sum9 != $signed({3'b000, w_rail}));

endmodule

`default_nettype wire

// File: rtl/gun_aim_ctrl.sv
//==============================================================================
// Module      : gun_aim_ctrl
// Description : Light-gun crosshair sequencer for the williams2 core.
//               Tick edge detect, two axis controllers, saturating position
//               registers, recentre and the mouse-source flag.
// Ports       : clk_12          12 MHz clock
//               reset           async active-high reset
//               tick_4ms        4 ms tick level; rising edge is used
//               joy_left/right/up/down  joystick, active high
//               recentre        1-cycle pulse, both axes to CENTER
//               mouse_dx/dy     signed deltas (dy +ve = up)
//               mouse_stb       deltas valid strobe
//               gun_h, gun_v    crosshair position (0 = left / top)
//               src_mouse       last movement came from the mouse
// Config      : GUN_MOUSE_EN merges mouse deltas; undefined -> mouse ports
//               ignored and src_mouse tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gun_aim_ctrl
    import gun_pkg::*;
#(
    parameter int SLOW_DIV    = 3,
    parameter int ACCEL_TICKS = 16,
    parameter int CENTER      = 32,
    parameter int MOUSE_SHIFT = 2
) (
    input  logic              clk_12,
    input  logic              reset,
    input  logic              tick_4ms,
    input  logic              joy_left,
    input  logic              joy_right,
    input  logic              joy_up,
    input  logic              joy_down,
    input  logic              recentre,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    input  logic              mouse_stb,
    output logic [GUN_W-1:0]  gun_h,
    output logic [GUN_W-1:0]  gun_v,
    output logic              src_mouse
);

    localparam logic [GUN_W-1:0] c_CENTER = GUN_W'(CENTER);
    localparam logic [GUN_W-1:0] c_MAX    = GUN_W'(GUN_MAX);

    logic                r_tick_d;
    logic                w_tick_p;
    logic signed [9:0]   w_dx;
    logic signed [9:0]   w_dy;
    logic [GUN_W-1:0]    r_gun_h, r_gun_v;
    logic [GUN_W-1:0]    w_h_nxt, w_v_nxt;
    logic signed [7:0]   w_h_step, w_v_step;
    logic signed [7:0]   w_h_sum8, w_v_sum8;
    logic                w_h_sat, w_v_sat;
    logic                w_h_joy_mv, w_v_joy_mv;
    logic                w_h_mouse_mv, w_v_mouse_mv;

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= tick_4ms;
        end
    end

    assign w_tick_p = tick_4ms & ~r_tick_d;

    // Y delta is negated (screen Y grows downward); 10 bits keeps -(-256).
    assign w_dx = 10'(mouse_dx);
    assign w_dy = -(10'(mouse_dy));

    gun_axis_ctrl #(
        .SLOW_DIV    (SLOW_DIV),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MOUSE_SHIFT (MOUSE_SHIFT)
    ) u_axis_h (
        .clk_12        (clk_12),
        .reset         (reset),
        .i_tick_p      (w_tick_p),
        .i_recentre    (recentre),
        .i_dir_neg     (joy_left),
        .i_dir_pos     (joy_right),
        .i_mouse_stb   (mouse_stb),
        .i_mouse_d     (w_dx),
        .i_pos         (r_gun_h),
        .o_step        (w_h_step),
        .o_sat         (w_h_sat),
        .o_joy_moved   (w_h_joy_mv),
        .o_mouse_moved (w_h_mouse_mv)
    );

    gun_axis_ctrl #(
        .SLOW_DIV    (SLOW_DIV),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MOUSE_SHIFT (MOUSE_SHIFT)
    ) u_axis_v (
        .clk_12        (clk_12),
        .reset         (reset),
        .i_tick_p      (w_tick_p),
        .i_recentre    (recentre),
        .i_dir_neg     (joy_up),
        .i_dir_pos     (joy_down),
        .i_mouse_stb   (mouse_stb),
        .i_mouse_d     (w_dy),
        .i_pos         (r_gun_v),
        .o_step        (w_v_step),
        .o_sat         (w_v_sat),
        .o_joy_moved   (w_v_joy_mv),
        .o_mouse_moved (w_v_mouse_mv)
    );

    // The 8-bit sum may wrap only when the axis already flags saturation,
    // in which case the rail is chosen from the step sign instead.
    assign w_h_sum8 = $signed({2'b00, r_gun_h}) + w_h_step;
    assign w_v_sum8 = $signed({2'b00, r_gun_v}) + w_v_step;
    assign w_h_nxt  = w_h_sat ? (w_h_step[7] ? '0 : c_MAX) : sat6(w_h_sum8);
    assign w_v_nxt  = w_v_sat ? (w_v_step[7] ? '0 : c_MAX) : sat6(w_v_sum8);

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            r_gun_h <= c_CENTER;
            r_gun_v <= c_CENTER;
        end else if (recentre) begin
            r_gun_h <= c_CENTER;
            r_gun_v <= c_CENTER;
        end else begin
            r_gun_h <= w_h_nxt;
            r_gun_v <= w_v_nxt;
        end
    end

`ifdef GUN_MOUSE_EN
    logic r_src_mouse;

    // A mouse step wins over a joystick step landing in the same cycle.
    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            r_src_mouse <= 1'b0;
        end else if (!recentre) begin
            if (mouse_stb && (w_h_mouse_mv || w_v_mouse_mv)) begin
                r_src_mouse <= 1'b1;
            end else if (w_h_joy_mv || w_v_joy_mv) begin
                r_src_mouse <= 1'b0;
            end
        end
    end

    assign src_mouse = r_src_mouse;
`else
    logic w_src_unused;

    assign w_src_unused = ^{w_h_joy_mv, w_v_joy_mv, w_h_mouse_mv, w_v_mouse_mv};
    assign src_mouse    = 1'b0;
`endif

    assign gun_h = r_gun_h;
    assign gun_v = r_gun_v;

endmodule

`default_nettype wire

// File: tb/tb_gun_aim_ctrl.sv
//==============================================================================
// Module      : tb_gun_aim_ctrl
// Description : Self-checking bench for gun_aim_ctrl. A tick-level model of
//               the aim rules is compared with the DUT on every falling edge;
//               directed sequences add hand-computed literal checkpoints.
// Config      : mouse sequences run only when GUN_MOUSE_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gun_aim_ctrl;

    localparam int c_SLOW_DIV = 3;
    localparam int c_ACCEL    = 16;
    localparam int c_CENTER   = 32;
    localparam int c_MDIV     = 4;

    logic              clk_12 = 1'b0;
    logic              reset;
    logic              tick_4ms;
    logic              joy_left, joy_right, joy_up, joy_down;
    logic              recentre;
    logic signed [8:0] mouse_dx, mouse_dy;
    logic              mouse_stb;
    logic [5:0]        gun_h, gun_v;
    logic              src_mouse;

    int n_checks = 0;
    int n_errors = 0;
    bit compare_en = 1'b0;

    always #5 clk_12 = ~clk_12;

    gun_aim_ctrl #(
        .SLOW_DIV    (c_SLOW_DIV),
        .ACCEL_TICKS (c_ACCEL),
        .CENTER      (c_CENTER),
        .MOUSE_SHIFT (2)
    ) dut (
        .clk_12    (clk_12),
        .reset     (reset),
        .tick_4ms  (tick_4ms),
        .joy_left  (joy_left),
        .joy_right (joy_right),
        .joy_up    (joy_up),
        .joy_down  (joy_down),
        .recentre  (recentre),
        .mouse_dx  (mouse_dx),
        .mouse_dy  (mouse_dy),
        .mouse_stb (mouse_stb),
        .gun_h     (gun_h),
        .gun_v     (gun_v),
        .src_mouse (src_mouse)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each press counts ticks n = 1, 2, ...; a step is due on ticks
    // 1, 1+SLOW_DIV, 1+2*SLOW_DIV ... and on every tick once n > ACCEL.
    int m_pos [2];
    int m_n   [2];
    int m_dir [2];
    int m_acc [2];
    bit m_src;
    bit m_tprev;
    int t_dir, t_js, t_ms, t_sum;
    bit t_tp, t_anyjs, t_anyms;

    function automatic int floor_div(input int a);
        return (a >= 0) ? (a / c_MDIV) : -((-a + c_MDIV - 1) / c_MDIV);
    endfunction

    always @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 2; a++) begin
                m_pos[a] = c_CENTER;
                m_n[a]   = 0;
                m_dir[a] = 0;
                m_acc[a] = 0;
            end
            m_src   = 1'b0;
            m_tprev = 1'b0;
        end else begin
            t_tp    = tick_4ms && !m_tprev;
            m_tprev = tick_4ms;
            if (recentre) begin
                for (int a = 0; a < 2; a++) begin
                    m_pos[a] = c_CENTER;
                    m_n[a]   = 0;
                    m_dir[a] = 0;
                    m_acc[a] = 0;
                end
            end else begin
                t_anyjs = 1'b0;
                t_anyms = 1'b0;
                for (int a = 0; a < 2; a++) begin
                    t_js  = 0;
                    t_ms  = 0;
                    t_dir = (a == 0) ? (int'(joy_right) - int'(joy_left))
                                     : (int'(joy_down) - int'(joy_up));
                    if (t_tp) begin
                        if (t_dir == 0) begin
                            m_n[a]   = 0;
                            m_dir[a] = 0;
                        end else begin
                            if (t_dir != m_dir[a]) begin
                                m_n[a]   = 1;
                                m_dir[a] = t_dir;
                            end else if (m_n[a] < 1000) begin
                                m_n[a]++;
                            end
                            if (m_n[a] > c_ACCEL || ((m_n[a] - 1) % c_SLOW_DIV) == 0)
                                t_js = t_dir;
                        end
                    end
`ifdef GUN_MOUSE_EN
                    if (mouse_stb) begin
                        m_acc[a] += (a == 0) ? int'(mouse_dx) : -int'(mouse_dy);
                        t_ms      = floor_div(m_acc[a]);
                        m_acc[a] -= t_ms * c_MDIV;
                    end
`endif
                    t_sum = m_pos[a] + t_js + t_ms;
                    if (t_sum < 0) begin
                        m_pos[a] = 0;
                        m_acc[a] = 0;
                    end else if (t_sum > 63) begin
                        m_pos[a] = 63;
                        m_acc[a] = 0;
                    end else begin
                        m_pos[a] = t_sum;
                    end
                    if (t_js != 0) t_anyjs = 1'b1;
                    if (t_ms != 0) t_anyms = 1'b1;
                end
                if (mouse_stb && t_anyms) m_src = 1'b1;
                else if (t_anyjs)         m_src = 1'b0;
            end
        end
    end

    always @(negedge clk_12) begin
        if (compare_en) begin
            check("model_gun_h", int'(gun_h), m_pos[0]);
            check("model_gun_v", int'(gun_v), m_pos[1]);
            check("model_src_mouse", int'(src_mouse), int'(m_src));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_tick();
        @(negedge clk_12) tick_4ms = 1'b1;
        repeat (2) @(negedge clk_12);
        tick_4ms = 1'b0;
        @(negedge clk_12);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_recentre();
        @(negedge clk_12) recentre = 1'b1;
        @(negedge clk_12) recentre = 1'b0;
        @(negedge clk_12);
    endtask

    task automatic mouse(input int dx, input int dy);
        @(negedge clk_12);
        mouse_stb = 1'b1;
        mouse_dx  = 9'(dx);
        mouse_dy  = 9'(dy);
        @(negedge clk_12);
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
    endtask

    initial begin
        reset     = 1'b1;
        tick_4ms  = 1'b0;
        joy_left  = 1'b0;
        joy_right = 1'b0;
        joy_up    = 1'b0;
        joy_down  = 1'b0;
        recentre  = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
        mouse_stb = 1'b0;
        repeat (3) @(negedge clk_12);
        reset = 1'b0;
        compare_en = 1'b1;

        // 1: reset values, no tick means no movement
        check("reset_gun_h", int'(gun_h), 32);
        check("reset_gun_v", int'(gun_v), 32);
        check("reset_src", int'(src_mouse), 0);
        joy_right = 1'b1;
        repeat (1000) @(negedge clk_12);
        check("no_tick_gun_h", int'(gun_h), 32);

        // 2: slow profile and release
        do_tick();
        check("right_tick1", int'(gun_h), 33);
        do_ticks(2);
        check("right_tick3", int'(gun_h), 33);
        do_tick();
        check("right_tick4", int'(gun_h), 34);
        joy_right = 1'b0;
        do_tick();
        check("release_tick5", int'(gun_h), 34);

        // 3: diagonal to the corners, acceleration, no wrap
        pulse_recentre();
        joy_left = 1'b1;
        joy_down = 1'b1;
        do_ticks(16);
        check("slow16_gun_h", int'(gun_h), 26);
        check("slow16_gun_v", int'(gun_v), 38);
        do_tick();
        check("fast17_gun_h", int'(gun_h), 25);
        check("fast17_gun_v", int'(gun_v), 39);
        do_ticks(83);
        check("left_floor_h", int'(gun_h), 0);
        check("down_ceil_v", int'(gun_v), 63);
        joy_left  = 1'b0;
        joy_down  = 1'b0;
        joy_right = 1'b1;
        do_tick();
        check("reverse_step_h", int'(gun_h), 1);
        do_tick();
        check("reverse_slow_h", int'(gun_h), 1);
        joy_left = 1'b1;
        do_tick();
        check("both_dirs_h", int'(gun_h), 1);
        joy_left  = 1'b0;
        joy_right = 1'b0;

`ifdef GUN_MOUSE_EN
        // 4: mouse accumulation with remainder
        pulse_recentre();
        mouse(6, 0);
        check("mouse_dx6_h", int'(gun_h), 33);
        check("mouse_src", int'(src_mouse), 1);
        mouse(2, 0);
        check("mouse_dx2_h", int'(gun_h), 34);
        mouse(0, 4);
        check("mouse_dy4_v", int'(gun_v), 31);
        mouse(-1, 0);
        check("mouse_neg_h", int'(gun_h), 33);
        mouse(1, 0);
        check("mouse_rem3_h", int'(gun_h), 34);

        // 5: tick and strobe in the same clock
        pulse_recentre();
        joy_right = 1'b1;
        @(negedge clk_12);
        tick_4ms  = 1'b1;
        mouse_stb = 1'b1;
        mouse_dx  = 9'sd4;
        @(negedge clk_12);
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        check("combo_h", int'(gun_h), 34);
        check("combo_src", int'(src_mouse), 1);
        @(negedge clk_12) tick_4ms = 1'b0;
        @(negedge clk_12);
        do_ticks(3);
        check("joy_after_mouse_h", int'(gun_h), 35);
        check("joy_clears_src", int'(src_mouse), 0);
`endif

        // 6: async reset mid-FAST, then recentre with a concurrent tick
        pulse_recentre();
        joy_right = 1'b1;
        do_ticks(28);
        check("fast_before_reset", int'(gun_h), 50);
        @(negedge clk_12);
        #2 reset = 1'b1;
        #1 check("async_reset_h", int'(gun_h), 32);
        repeat (2) @(negedge clk_12);
        reset = 1'b0;
        do_tick();
        check("first_press_after_reset", int'(gun_h), 33);
        do_tick();
        check("second_tick_after_reset", int'(gun_h), 33);
        @(negedge clk_12);
        recentre = 1'b1;
        tick_4ms = 1'b1;
        @(negedge clk_12);
        recentre = 1'b0;
        check("recentre_with_tick", int'(gun_h), 32);
        @(negedge clk_12) tick_4ms = 1'b0;
        @(negedge clk_12);
        do_tick();
        check("press_after_recentre", int'(gun_h), 33);

        compare_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
